// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified instruction/data RAM port: owner tags,
// arbiter state and the response tag carried down the read-latency pipe.
package arm_mem_pkg;

  localparam int MEM_ADDR_W = 11;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} mem_owner_e;

  typedef enum logic {ARB_NORMAL, ARB_FETCH_PRIO} arb_state_e;

  typedef struct packed {
    logic       vld;
    mem_owner_e own;
  } rsp_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and RAM-side signals of the shared memory port.
// slave is the arbiter's view; master is the requester/RAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = arm_mem_pkg::MEM_ADDR_W,
  parameter int DATA_W = arm_mem_pkg::MEM_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wren, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wren, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rsp_tracker.sv
// Carries one {valid, owner} tag per granted read through the RAM read
// latency and steers mem_rdata to the port that issued the read.
module mem_rsp_tracker
  import arm_mem_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  rsp_tag_t          push,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata
);

  rsp_tag_t [RD_LAT:1] tag_pipe;
  rsp_tag_t            tag_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[1] <= push;
      for (int i = 2; i <= RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_out   = tag_pipe[RD_LAT];
  assign if_rvalid = tag_out.vld && (tag_out.own == OWN_IF);
  assign d_rvalid  = tag_out.vld && (tag_out.own == OWN_D);
  // Non-owning port sees zero so stale data never leaks across requesters.
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single RAM port between fetch and load/store: data wins
// by default, fetch is forced through after FETCH_STARVE_MAX lost cycles.
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W           = MEM_ADDR_W,
  parameter int DATA_W           = MEM_DATA_W,
  parameter int RD_LAT           = 1,
  parameter int FETCH_STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(FETCH_STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FETCH_STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              if_win, d_win;
  rsp_tag_t          push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_NORMAL;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= bus.mem_addr;
    end
  end

  always_comb begin
    if_win  = 1'b0;
    d_win   = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst_n) begin
      unique case (state_q)
        ARB_NORMAL: begin
          d_win  = bus.d_req;
          if_win = bus.if_req && !bus.d_req;
        end
        ARB_FETCH_PRIO: begin
          if_win = bus.if_req;
          d_win  = bus.d_req && !bus.if_req;
        end
        default: ;
      endcase
    end

    if (if_win)
      cnt_d = '0;
    else if (d_win && bus.if_req && (cnt_q < CNT_MAX))
      cnt_d = cnt_q + CNT_W'(1);

    unique case (state_q)
      ARB_NORMAL:
        if (cnt_d == CNT_MAX) state_d = ARB_FETCH_PRIO;
      ARB_FETCH_PRIO:
        // A withdrawn fetch also clears the count so NORMAL is not re-entered saturated.
        if (if_win || !bus.if_req) begin
          state_d = ARB_NORMAL;
          cnt_d   = '0;
        end
      default: ;
    endcase
  end

  assign bus.if_gnt    = if_win;
  assign bus.d_gnt     = d_win;
  assign bus.mem_wren  = d_win && bus.d_we;
  assign bus.mem_wdata = d_win ? bus.d_wdata : '0;
  assign bus.mem_addr  = if_win ? bus.if_addr : (d_win ? bus.d_addr : addr_q);

  always_comb begin
    push = '0;
    if (if_win) begin
      push.vld = 1'b1;
      push.own = OWN_IF;
    end else if (d_win && !bus.d_we) begin
      push.vld = 1'b1;
      push.own = OWN_D;
    end
  end

  mem_rsp_tracker #(
    .RD_LAT (RD_LAT),
    .DATA_W (DATA_W)
  ) u_rsp (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .mem_rdata (bus.mem_rdata),
    .if_rvalid (bus.if_rvalid),
    .if_rdata  (bus.if_rdata),
    .d_rvalid  (bus.d_rvalid),
    .d_rdata   (bus.d_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector table plus a reset-mid-read sequence for mem_port_arbiter,
// with a write-first RAM model (RD_LAT=1) behind the port.
module tb_mem_port_arbiter;
  import arm_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(11), .DATA_W(32), .RD_LAT(1), .FETCH_STARVE_MAX(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [2048];

  always @(posedge clk) begin
    if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= bus.mem_wren ? bus.mem_wdata : mem[bus.mem_addr];
  end

  typedef struct {
    string       name;
    logic        rst_n;
    logic        if_req;
    logic [10:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [10:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_if_rv;
    logic [31:0] e_if_rd;
    logic        e_d_rv;
    logic [31:0] e_d_rd;
    logic        e_wren;
    logic [10:0] e_addr;
  } vec_t;

  vec_t vt[$];
  int n_chk = 0;
  int n_err = 0;

  function automatic logic [31:0] m(input logic [10:0] a);
    return 32'hA000_0000 | {21'd0, a};
  endfunction

  function automatic vec_t mk(input string nm, input logic r, input logic ir,
                              input logic [10:0] ia, input logic dr, input logic dw,
                              input logic [10:0] da, input logic [31:0] dd,
                              input logic eig, input logic edg, input logic eiv,
                              input logic [31:0] eid, input logic edv,
                              input logic [31:0] edd, input logic ew,
                              input logic [10:0] ea);
    vec_t v;
    v.name = nm; v.rst_n = r; v.if_req = ir; v.if_addr = ia; v.d_req = dr;
    v.d_we = dw; v.d_addr = da; v.d_wdata = dd; v.e_if_gnt = eig;
    v.e_d_gnt = edg; v.e_if_rv = eiv; v.e_if_rd = eid; v.e_d_rv = edv;
    v.e_d_rd = edd; v.e_wren = ew; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n       = v.rst_n;
    bus.if_req  = v.if_req;
    bus.if_addr = v.if_addr;
    bus.d_req   = v.d_req;
    bus.d_we    = v.d_we;
    bus.d_addr  = v.d_addr;
    bus.d_wdata = v.d_wdata;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = m(11'(i));
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0;

    //            name           rst if  ifaddr  d  we daddr   wdata         ifg dg ifv ifrd            dv drd            wr addr
    vt.push_back(mk("reset",      0, 1, 11'h010, 1, 0, 11'h100, 32'h0,        0, 0, 0, 32'h0,          0, 32'h0,          0, 11'h000));
    vt.push_back(mk("fetch0",     1, 1, 11'h010, 0, 0, 11'h000, 32'h0,        1, 0, 0, 32'h0,          0, 32'h0,          0, 11'h010));
    vt.push_back(mk("fetch1",     1, 1, 11'h011, 0, 0, 11'h000, 32'h0,        1, 0, 1, m(11'h010),     0, 32'h0,          0, 11'h011));
    vt.push_back(mk("fetch2",     1, 1, 11'h012, 0, 0, 11'h000, 32'h0,        1, 0, 1, m(11'h011),     0, 32'h0,          0, 11'h012));
    vt.push_back(mk("fetch_drain",1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        0, 0, 1, m(11'h012),     0, 32'h0,          0, 11'h012));
    vt.push_back(mk("contend",    1, 1, 11'h000, 1, 0, 11'h100, 32'h0,        0, 1, 0, 32'h0,          0, 32'h0,          0, 11'h100));
    vt.push_back(mk("contend_rsp",1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        0, 0, 0, 32'h0,          1, m(11'h100),     0, 11'h100));
    vt.push_back(mk("fetch_clr",  1, 1, 11'h000, 0, 0, 11'h000, 32'h0,        1, 0, 0, 32'h0,          0, 32'h0,          0, 11'h000));
    vt.push_back(mk("clr_rsp",    1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        0, 0, 1, m(11'h000),     0, 32'h0,          0, 11'h000));
    vt.push_back(mk("starve0",    1, 1, 11'h001, 1, 0, 11'h101, 32'h0,        0, 1, 0, 32'h0,          0, 32'h0,          0, 11'h101));
    vt.push_back(mk("starve1",    1, 1, 11'h001, 1, 0, 11'h101, 32'h0,        0, 1, 0, 32'h0,          1, m(11'h101),     0, 11'h101));
    vt.push_back(mk("starve2",    1, 1, 11'h001, 1, 0, 11'h101, 32'h0,        0, 1, 0, 32'h0,          1, m(11'h101),     0, 11'h101));
    vt.push_back(mk("starve3",    1, 1, 11'h001, 1, 0, 11'h101, 32'h0,        0, 1, 0, 32'h0,          1, m(11'h101),     0, 11'h101));
    vt.push_back(mk("starve4",    1, 1, 11'h001, 1, 0, 11'h101, 32'h0,        1, 0, 0, 32'h0,          1, m(11'h101),     0, 11'h001));
    vt.push_back(mk("starve5",    1, 1, 11'h001, 1, 0, 11'h101, 32'h0,        0, 1, 1, m(11'h001),     0, 32'h0,          0, 11'h101));
    vt.push_back(mk("starve_rsp", 1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        0, 0, 0, 32'h0,          1, m(11'h101),     0, 11'h101));
    vt.push_back(mk("store",      1, 0, 11'h000, 1, 1, 11'h020, 32'hDEADBEEF, 0, 1, 0, 32'h0,          0, 32'h0,          1, 11'h020));
    vt.push_back(mk("rd_after_st",1, 1, 11'h020, 0, 0, 11'h000, 32'h0,        1, 0, 0, 32'h0,          0, 32'h0,          0, 11'h020));
    vt.push_back(mk("rd_rsp",     1, 0, 11'h000, 1, 0, 11'h020, 32'h0,        0, 1, 1, 32'hDEADBEEF,   0, 32'h0,          0, 11'h020));
    vt.push_back(mk("d_rsp",      1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        0, 0, 0, 32'h0,          1, 32'hDEADBEEF,   0, 11'h020));

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      drive(vt[i]);
      @(negedge clk);
      chk({vt[i].name, ".if_gnt"},    {31'd0, bus.if_gnt},    {31'd0, vt[i].e_if_gnt});
      chk({vt[i].name, ".d_gnt"},     {31'd0, bus.d_gnt},     {31'd0, vt[i].e_d_gnt});
      chk({vt[i].name, ".if_rvalid"}, {31'd0, bus.if_rvalid}, {31'd0, vt[i].e_if_rv});
      chk({vt[i].name, ".if_rdata"},  bus.if_rdata,           vt[i].e_if_rd);
      chk({vt[i].name, ".d_rvalid"},  {31'd0, bus.d_rvalid},  {31'd0, vt[i].e_d_rv});
      chk({vt[i].name, ".d_rdata"},   bus.d_rdata,            vt[i].e_d_rd);
      chk({vt[i].name, ".mem_wren"},  {31'd0, bus.mem_wren},  {31'd0, vt[i].e_wren});
      chk({vt[i].name, ".mem_addr"},  {21'd0, bus.mem_addr},  {21'd0, vt[i].e_addr});
    end
    chk("store.wdata_in_ram", mem[11'h020], 32'hDEADBEEF);

    // Reset asserted while a load is in flight: its response must vanish.
    @(posedge clk); #1;
    bus.if_req = 0; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 11'h030;
    @(negedge clk);
    chk("rstmid.d_gnt", {31'd0, bus.d_gnt}, 32'd1);
    @(posedge clk); #1;
    bus.d_req = 0; rst_n = 0;
    @(negedge clk);
    chk("rstmid.d_rvalid_in_rst", {31'd0, bus.d_rvalid}, 32'd0);
    chk("rstmid.d_rdata_in_rst",  bus.d_rdata, 32'd0);
    chk("rstmid.mem_addr_in_rst", {21'd0, bus.mem_addr}, 32'd0);
    chk("rstmid.mem_wdata_in_rst", bus.mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstmid.d_rvalid_after", {31'd0, bus.d_rvalid}, 32'd0);
      chk("rstmid.if_rvalid_after", {31'd0, bus.if_rvalid}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
